// File: rtl/dsa_modmul_pkg.sv
// Shared definitions for the DSA modular multiplier: default width, FSM
// encoding and counter sizing.
package dsa_modmul_pkg;

  localparam int unsigned DsaSize = 256;

  // Unused code 2'b11 falls back to StIdle in the FSM.
  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StMul  = 2'b01,
    StDone = 2'b10
  } state_e;

  // Bit counter width, never less than one bit.
  function automatic int unsigned cnt_width(int unsigned size);
    return (size > 1) ? $clog2(size) : 1;
  endfunction

  localparam int unsigned DsaCntW = cnt_width(DsaSize);

endpackage

// File: rtl/dsa_modmul_step.sv
// One interleaved double-and-add step: r_next = (2r + k*a) mod p, assuming r < p and a < p.
module dsa_modmul_step
  import dsa_modmul_pkg::*;
#(
  parameter int unsigned SIZE = DsaSize
) (
  input  logic [SIZE:0]   r_i,
  input  logic [SIZE-1:0] a_i,
  input  logic [SIZE-1:0] p_i,
  input  logic            k_i,
  output logic [SIZE:0]   r_next_o
);

  logic [SIZE:0] p_ext;
  logic [SIZE:0] t_dbl;
  logic [SIZE:0] t;
  logic [SIZE:0] u_sum;
  logic [SIZE:0] u;

  // Double, reduce once, add, reduce once; each sum stays below 2p so it fits SIZE+1 bits.
  always_comb begin
    p_ext    = {1'b0, p_i};
    t_dbl    = r_i << 1;
    t        = (t_dbl >= p_ext) ? (t_dbl - p_ext) : t_dbl;
    u_sum    = t + (k_i ? {1'b0, a_i} : '0);
    u        = (u_sum >= p_ext) ? (u_sum - p_ext) : u_sum;
    r_next_o = u;
  end

endmodule

// File: rtl/dsa_modmul.sv
// Bit-serial modular multiplier c = a*b mod p, one bit of b per clock, MSB first.
module dsa_modmul
  import dsa_modmul_pkg::*;
#(
  parameter int unsigned SIZE = DsaSize
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            en_i,
  input  logic [SIZE-1:0] a_i,
  input  logic [SIZE-1:0] b_i,
  input  logic [SIZE-1:0] p_i,
  output logic            rdy_o,
  output logic [SIZE-1:0] c_o
);

  localparam int unsigned CntW = cnt_width(SIZE);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [SIZE-1:0] a_q, a_d;
  logic [SIZE-1:0] b_q, b_d;
  logic [SIZE-1:0] p_q, p_d;
  logic [SIZE:0]   r_q, r_d;
  logic [SIZE-1:0] c_q, c_d;
  logic            rdy_q, rdy_d;
  logic [SIZE:0]   r_next;

  dsa_modmul_step #(
    .SIZE(SIZE)
  ) u_step (
    .r_i     (r_q),
    .a_i     (a_q),
    .p_i     (p_q),
    .k_i     (b_q[cnt_q]),
    .r_next_o(r_next)
  );

  // Next-state: load in idle, step in mul, hold in done; en low aborts from any state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    p_d     = p_q;
    r_d     = r_q;
    c_d     = c_q;
    rdy_d   = rdy_q;
    if (!en_i) begin
      state_d = StIdle;
      r_d     = '0;
      c_d     = '0;
      rdy_d   = 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          a_d     = a_i;
          b_d     = b_i;
          p_d     = p_i;
          r_d     = '0;
          cnt_d   = CntW'(SIZE - 1);
          state_d = StMul;
        end
        StMul: begin
          r_d = r_next;
          if (cnt_q == '0) begin
            c_d     = r_next[SIZE-1:0];
            rdy_d   = 1'b1;
            state_d = StDone;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        StDone: ;
        default: state_d = StIdle;
      endcase
    end
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      r_q     <= '0;
      c_q     <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      p_q     <= p_d;
      r_q     <= r_d;
      c_q     <= c_d;
      rdy_q   <= rdy_d;
    end
  end

  assign rdy_o = rdy_q;
  assign c_o   = c_q;

endmodule

// File: tb/tb_dsa_modmul.sv
// Scoreboard bench for dsa_modmul at SIZE=8 and SIZE=256.
module tb_dsa_modmul;

  localparam logic [255:0] PrimeP =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

  typedef struct {
    logic [255:0] c;
    int unsigned  edge_n;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         en8, en256;
  logic [7:0]   a8, b8, p8, c8;
  logic [255:0] a256, b256, p256, c256;
  logic         rdy8, rdy256;
  logic         rdy8_prev = 1'b0, rdy256_prev = 1'b0;
  int unsigned  cyc = 0;
  int           n_checks = 0;
  int           n_fail = 0;
  exp_t         q8[$];
  exp_t         q256[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dsa_modmul #(.SIZE(8)) u_dut8 (
    .clk_i(clk), .rst_i(rst), .en_i(en8), .a_i(a8), .b_i(b8), .p_i(p8),
    .rdy_o(rdy8), .c_o(c8)
  );

  dsa_modmul #(.SIZE(256)) u_dut256 (
    .clk_i(clk), .rst_i(rst), .en_i(en256), .a_i(a256), .b_i(b256), .p_i(p256),
    .rdy_o(rdy256), .c_o(c256)
  );

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitors: on each rdy rising edge pop the oldest expectation and compare result and edge.
  always @(negedge clk) begin
    exp_t e;
    if (rdy8 && !rdy8_prev) begin
      if (q8.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rdy8_unexpected: got rdy=1 c=%0h required no result", c8);
      end else begin
        e = q8.pop_front();
        check("c8", {248'b0, c8}, e.c);
        check("lat8", 256'(cyc), 256'(e.edge_n));
      end
    end
    rdy8_prev = rdy8;
  end

  always @(negedge clk) begin
    exp_t e;
    if (rdy256 && !rdy256_prev) begin
      if (q256.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rdy256_unexpected: got rdy=1 c=%0h required no result", c256);
      end else begin
        e = q256.pop_front();
        check("c256", c256, e.c);
        check("lat256", 256'(cyc), 256'(e.edge_n));
      end
    end
    rdy256_prev = rdy256;
  end

  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] p,
                        input logic [7:0] exp_c);
    exp_t e;
    @(negedge clk);
    a8 = a; b8 = b; p8 = p; en8 = 1'b1;
    e.c = {248'b0, exp_c};
    e.edge_n = cyc + 1 + 8;
    q8.push_back(e);
  endtask

  task automatic issue256(input logic [255:0] a, input logic [255:0] b,
                          input logic [255:0] p, input logic [255:0] exp_c);
    exp_t e;
    @(negedge clk);
    a256 = a; b256 = b; p256 = p; en256 = 1'b1;
    e.c = exp_c;
    e.edge_n = cyc + 1 + 256;
    q256.push_back(e);
  endtask

  task automatic drain8(input string name);
    for (int i = 0; i < 20 && q8.size() != 0; i++) @(negedge clk);
    #1;
    if (q8.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got no rdy required rdy within 20 edges", name);
      q8.delete();
    end
  endtask

  task automatic drain256(input string name);
    for (int i = 0; i < 300 && q256.size() != 0; i++) @(negedge clk);
    #1;
    if (q256.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got no rdy required rdy within 300 edges", name);
      q256.delete();
    end
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [255:0] ra, rb, rp, rexp;
    logic [511:0] prod;
    rst = 1'b1; en8 = 1'b0; en256 = 1'b0;
    a8 = '0; b8 = '0; p8 = '0; a256 = '0; b256 = '0; p256 = '0;
    #12;
    check("reset_rdy8", {255'b0, rdy8}, 256'd0);
    check("reset_c8", {248'b0, c8}, 256'd0);
    check("reset_rdy256", {255'b0, rdy256}, 256'd0);
    check("reset_c256", c256, 256'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 5*7 mod 11 = 35 mod 11 = 2; result held and inputs ignored while en stays high.
    issue8(8'd5, 8'd7, 8'd11, 8'd2);
    drain8("t_5x7");
    a8 = 8'd1; b8 = 8'd1; p8 = 8'd3;
    repeat (3) @(negedge clk);
    check("hold_c8", {248'b0, c8}, 256'd2);
    check("hold_rdy8", {255'b0, rdy8}, 256'd1);
    en8 = 1'b0;
    @(negedge clk);
    check("drop_rdy8", {255'b0, rdy8}, 256'd0);
    check("drop_c8", {248'b0, c8}, 256'd0);

    // 10*255 mod 13 = 2550 mod 13 = 2.
    issue8(8'd10, 8'd255, 8'd13, 8'd2);
    drain8("t_10x255");
    @(negedge clk); en8 = 1'b0;
    @(negedge clk);

    // Abort mid-multiply, then 3*4 mod 7 = 5 from a clean start.
    a8 = 8'd9; b8 = 8'd200; p8 = 8'd251; en8 = 1'b1;
    repeat (4) @(negedge clk);
    en8 = 1'b0;
    @(negedge clk);
    check("abort_rdy8", {255'b0, rdy8}, 256'd0);
    check("abort_c8", {248'b0, c8}, 256'd0);
    issue8(8'd3, 8'd4, 8'd7, 8'd5);
    drain8("t_3x4");
    @(negedge clk); en8 = 1'b0;
    @(negedge clk);

    // Reset while holding a result clears outputs without waiting for a clock edge.
    issue8(8'd6, 8'd6, 8'd11, 8'd3);
    drain8("t_6x6");
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_done_rdy8", {255'b0, rdy8}, 256'd0);
    check("arst_done_c8", {248'b0, c8}, 256'd0);
    en8 = 1'b0;
    @(negedge clk); rst = 1'b0;
    repeat (5) @(negedge clk);
    check("post_rst_rdy8", {255'b0, rdy8}, 256'd0);

    // Reset pulse mid-multiply: no result appears until a fresh start.
    a8 = 8'd7; b8 = 8'd9; p8 = 8'd13; en8 = 1'b1;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_mul_rdy8", {255'b0, rdy8}, 256'd0);
    check("arst_mul_c8", {248'b0, c8}, 256'd0);
    en8 = 1'b0;
    @(negedge clk); rst = 1'b0;
    repeat (15) @(negedge clk);
    check("idle_rdy8", {255'b0, rdy8}, 256'd0);
    issue8(8'd3, 8'd4, 8'd7, 8'd5);
    drain8("t_3x4_again");
    @(negedge clk); en8 = 1'b0;

    // 256-bit: (p-1)^2 mod p = 1, (p-1)*0 mod p = 0.
    issue256(PrimeP - 256'd1, PrimeP - 256'd1, PrimeP, 256'd1);
    drain256("t_pm1_sq");
    @(negedge clk); en256 = 1'b0;
    @(negedge clk);
    issue256(PrimeP - 256'd1, 256'd0, PrimeP, 256'd0);
    drain256("t_pm1_x0");
    @(negedge clk); en256 = 1'b0;
    @(negedge clk);

    // Random 256-bit vectors against a bignum reference.
    for (int i = 0; i < 12; i++) begin
      rp = rnd256();
      if (i % 2 == 0) rp = PrimeP;
      if (rp < 256'd2) rp = 256'd2;
      ra = rnd256() % rp;
      rb = rnd256();
      prod = {256'b0, ra} * {256'b0, rb};
      prod = prod % {256'b0, rp};
      rexp = prod[255:0];
      issue256(ra, rb, rp, rexp);
      drain256("t_rand");
      @(negedge clk); en256 = 1'b0;
      @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
